gi_kexp: RTL and testbench
==========================

# gi_kexp

AES-128 key expansion engine: the writer side of the GI decryption key buffer. On `start` it takes a 128-bit cipher key, computes the 11 round keys one per cycle, and streams them to the key buffer via `kld`/`kout` in order rk0 … rk10. Once loading finishes, the buffer presents rk10 first, which is the order the decryption core consumes them. It sits between the GI key register file and the key buffer, and runs once per key change, never per data block.

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only when `busy`=0.
- `key`  in  128  cipher key; byte 0 = `key[127:120]`; sampled in the `start` cycle only.
- `busy`  out  1  expansion/load in progress.
- `done`  out  1  single-cycle pulse: all 11 round keys have been loaded.
- `kld`  out  1  load strobe to the key buffer; leads the matching `kout` word by one cycle.
- `kout`  out  128  round key presented to the key buffer.

## Operation
- FSM states: IDLE → LOAD → FIN → IDLE.
- IDLE: `busy`=0. `start`=1 latches `key` into round-key register `rk`, clears round counter `rc`=0, and moves to LOAD.
- LOAD, 11 cycles, `rc`=0..10:
  - `kld`=1 every cycle.
  - `rk` updates each cycle to the next round key, and `kout` follows `rk` one cycle later.
  - After `rc`=10, move to FIN.
- FIN, 1 cycle: `kld`=0, last word on `kout`, `done`=1, then return to IDLE.
- Round function, words w0=`rk[127:96]` … w3=`rk[31:0]`:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, with RotWord(w)={w[23:0],w[31:24]}.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36. Generate it as a shift/xtime register, not a table indexed by `rc`.
- `start` while `busy`=1: ignored, with no effect on the sequence in progress.
- `key` changing while `busy`=1: no effect; only the `start`-cycle value is used.
- Reset mid-operation:
  - Next cycle: IDLE, `kld`=0, `done`=0, `busy`=0.
  - The key buffer is left partially loaded, and the controller must issue a new `start`.
- The sequence must not be interrupted by data traffic. The key buffer is a circular shift register and is only consistent after all 11 loads.

## Timing
- Cycle 0: `start` accepted.
- Cycles 1..11: `kld`=1.
- Cycles 2..12: `kout`=rk0..rk10 respectively.
- Cycle 12: `done`=1.
- `busy`=1 in cycles 1..12; the earliest next `start` is cycle 13.
- Total latency `start` → `done` is 12 cycles.
- `kld`-to-`kout` one-cycle lead matches the key buffer's registered load strobe. That is, the buffer captures `kout` in the cycle after it sees `kld`.
- Reset values: `busy`=0, `done`=0, `kld`=0, `kout`=128'h0.
- Critical path, one round per cycle: 1 S-box + 4 chained XORs.

## Configuration
- `GI_KEXP_IMC_EN` defined:
  - rk1..rk9 pass through InvMixColumns (applied per 32-bit column) before driving `kout`.
  - This produces keys for the equivalent inverse cipher.
  - rk0 and rk10 are unmodified, and the recurrence still uses the untransformed `rk`.
  - Latency is unchanged: the transform sits in the `kout` register input path.
- Not defined: `kout` carries the raw FIPS-197 round keys, and no InvMixColumns logic is built.

## Structure
- Shared include `gi_aes_defs.vh`:
  - Round count (11) and key width (128).
  - rcon initial value (8'h01) and reduction polynomial (8'h1b).
  - FSM state encodings.
- Sub-module `gi_aes_sbox`: combinational 8-bit forward S-box, instantiated 4×. It is reusable by the cipher core.
- InvMixColumns under the macro is a function in `gi_aes_defs.vh`, not a separate module.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c, macro off:
  - `kout` in cycle 2 = the key itself.
  - Cycle 3 = a0fafe1788542cb123a339392a6c7605.
  - Cycle 12 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` in cycle 12 only.
- Key all-zero, macro off:
  - rk1 = 62636363626363636263636362636363.
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Exactly 11 `kld` cycles.
- Attached to the key buffer, FIPS key: after `done`, the buffer output = rk10, and successive buffer shifts give rk9 … rk0, then wrap back to rk10.
- `start` pulsed in cycles 0 and 5 with different keys: the second is ignored, and rk10 matches the first key.
- `reset` asserted in cycle 6:
  - Cycle 7: `kld`=0, `busy`=0, `kout`=0.
  - A new `start` in cycle 8 gives a full correct sequence.
- `GI_KEXP_IMC_EN`, FIPS key:
  - rk0 and rk10 are as in the first scenario.
  - rk1..rk9 equal InvMixColumns of the raw keys, checked against the C reference model.

Source files
------------

// File: rtl/gi_kexp_pkg.sv
// gi_kexp_pkg: shared AES-128 key-expansion constants, FSM states and helpers.
// Optional GI_KEXP_IMC_EN adds the InvMixColumns helper for equivalent inverse keys.
package gi_kexp_pkg;

    localparam int          NR        = 11;
    localparam int          KW        = 128;
    localparam logic [3:0]  RC_LAST   = 4'd10;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  RPOLY     = 8'h1b;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Multiply by x in GF(2^8); also drives the rcon sequence.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? RPOLY : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

`ifdef GI_KEXP_IMC_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        inv_mix = {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                   inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction
`endif

endpackage

// File: rtl/gi_kexp_if.sv
// gi_kexp_if: key-expansion bus. master = key register file / controller side,
// slave = expansion engine. Carries start/key in and busy/done/kld/kout out.
interface gi_kexp_if;
    import gi_kexp_pkg::*;

    logic          start;
    logic [KW-1:0] key;
    logic          busy;
    logic          done;
    logic          kld;
    logic [KW-1:0] kout;

    modport master (
        output start, key,
        input  busy, done, kld, kout
    );

    modport slave (
        input  start, key,
        output busy, done, kld, kout
    );

endinterface

// File: rtl/gi_aes_sbox.sv
// gi_aes_sbox: combinational AES forward S-box, one byte.
// Ports: a (in, 8) input byte; y (out, 8) substituted byte.
module gi_aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/gi_kexp.sv
// gi_kexp: AES-128 key expansion, streams rk0..rk10 to the key buffer.
// Ports: clk, reset (sync, active-high), bus (gi_kexp_if.slave). Macro GI_KEXP_IMC_EN.
module gi_kexp
    import gi_kexp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    gi_kexp_if.slave  bus
);

    state_t        state;
    logic [KW-1:0] rk;
    logic [3:0]    rc;
    logic [7:0]    rcon;
    logic          busy_q;
    logic          done_q;
    logic          kld_q;
    logic [KW-1:0] kout_q;

    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   rot, sub, t;
    logic [31:0]   n0, n1, n2, n3;
    logic [KW-1:0] rk_next;
    logic [KW-1:0] kout_d;

    assign w0  = rk[127:96];
    assign w1  = rk[95:64];
    assign w2  = rk[63:32];
    assign w3  = rk[31:0];
    assign rot = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_sb
        gi_aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .y (sub[8*i +: 8])
        );
    end

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    // Only the outgoing word is transformed; the recurrence stays raw.
`ifdef GI_KEXP_IMC_EN
    assign kout_d = (rc != 4'd0 && rc != RC_LAST) ? inv_mix(rk) : rk;
`else
    assign kout_d = rk;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            rk     <= '0;
            rc     <= '0;
            rcon   <= RCON_INIT;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            kld_q  <= 1'b0;
            kout_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        rk     <= bus.key;
                        rc     <= '0;
                        rcon   <= RCON_INIT;
                        kld_q  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    kout_q <= kout_d;
                    rk     <= rk_next;
                    rcon   <= xtime(rcon);
                    rc     <= rc + 4'd1;
                    if (rc == RC_LAST) begin
                        kld_q  <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.kld  = kld_q;
    assign bus.kout = kout_q;

endmodule

// File: tb/tb_gi_kexp.sv
// tb_gi_kexp: directed self-checking bench for gi_kexp with a key-buffer model.
// Drives/samples on negedge; cycle n is the interval after posedge n-1.
module tb_gi_kexp;

    logic clk = 1'b0;
    logic reset;
    logic shift;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gi_kexp_if bus ();

    gi_kexp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] exp_rk [11];
    logic [10:0]  exp_mask;
    logic [127:0] kbuf [11];
    logic         kld_d;

    // Key buffer model: registered load strobe, shift-in on load,
    // rotate toward lower rounds on shift.
    always @(posedge clk) begin
        kld_d <= bus.kld;
        if (kld_d) begin
            kbuf[0] <= bus.kout;
            for (int i = 1; i < 11; i++) kbuf[i] <= kbuf[i-1];
        end else if (shift) begin
            for (int i = 0; i < 10; i++) kbuf[i] <= kbuf[i+1];
            kbuf[10] <= kbuf[0];
        end
    end

`ifdef GI_KEXP_IMC_EN
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0] m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gm(s[127-32*c-8*k -: 8], m[(k - row + 4) % 4]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction
`endif

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One start/expansion sequence; optional extra start at poke_cyc and
    // reset at rst_cyc (sequence then ends after the reset check).
    task automatic run(input string tag, input logic [127:0] k,
                       input int poke_cyc, input logic [127:0] poke_key,
                       input int rst_cyc);
        int nkld = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.key   = ~k;
            end
            if (rst_cyc != 0 && c == rst_cyc + 1) begin
                chk({tag, " rst kld"},  {127'h0, bus.kld},  128'h0);
                chk({tag, " rst busy"}, {127'h0, bus.busy}, 128'h0);
                chk({tag, " rst done"}, {127'h0, bus.done}, 128'h0);
                chk({tag, " rst kout"}, bus.kout, 128'h0);
                reset = 1'b0;
                return;
            end
            if (bus.kld) nkld++;
            chk($sformatf("%s kld c%0d", tag, c), {127'h0, bus.kld},
                {127'h0, (c <= 11)});
            chk($sformatf("%s busy c%0d", tag, c), {127'h0, bus.busy},
                {127'h0, (c <= 12)});
            chk($sformatf("%s done c%0d", tag, c), {127'h0, bus.done},
                {127'h0, (c == 12)});
            if (c >= 2 && c <= 12 && exp_mask[c-2])
                chk($sformatf("%s kout c%0d", tag, c), bus.kout, exp_rk[c-2]);
            if (c == poke_cyc) begin
                bus.start = 1'b1;
                bus.key   = poke_key;
            end else if (poke_cyc != 0 && c == poke_cyc + 1) begin
                bus.start = 1'b0;
            end
            if (c == rst_cyc) reset = 1'b1;
        end
        chk({tag, " kld count"}, 128'(nkld), 128'd11);
    endtask

    initial begin
        reset     = 1'b1;
        shift     = 1'b0;
        kld_d     = 1'b0;
        bus.start = 1'b0;
        bus.key   = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {127'h0, bus.busy}, 128'h0);
        chk("reset done", {127'h0, bus.done}, 128'h0);
        chk("reset kld",  {127'h0, bus.kld},  128'h0);
        chk("reset kout", bus.kout, 128'h0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) exp_rk[i] = fips_rk[i];
`ifdef GI_KEXP_IMC_EN
        for (int i = 1; i < 10; i++) exp_rk[i] = ref_imc(fips_rk[i]);
`endif
        exp_mask = 11'h7ff;
        run("fips", FIPS, 0, '0, 0);

        // Buffer presents rk10, then rk9..rk0, then wraps to rk10.
        @(negedge clk);
        chk("kbuf head", kbuf[0], exp_rk[10]);
        for (int i = 9; i >= 0; i--) begin
            shift = 1'b1;
            @(negedge clk);
            chk($sformatf("kbuf rk%0d", i), kbuf[0], exp_rk[i]);
        end
        @(negedge clk);
        chk("kbuf wrap", kbuf[0], exp_rk[10]);
        shift = 1'b0;

`ifndef GI_KEXP_IMC_EN
        for (int i = 0; i < 11; i++) exp_rk[i] = '0;
        exp_rk[1]  = 128'h62636363626363636263636362636363;
        exp_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        exp_mask   = 11'b10000000011;
        run("zero", 128'h0, 0, '0, 0);
        for (int i = 0; i < 11; i++) exp_rk[i] = fips_rk[i];
`endif

        exp_mask = 11'h7ff;
        run("poke", FIPS, 5, {128{1'b1}}, 0);
        run("abort", FIPS, 0, '0, 6);
        run("restart", FIPS, 0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
